// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity-mode names and the parity helper.
// Used by both uart_tx and uart_rx.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Accepted values of the PARITY string parameter
  localparam string PARITY_NONE = "none";
  localparam string PARITY_EVEN = "even";
  localparam string PARITY_ODD  = "odd";

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_mode_t;

  // Payloads are zero-extended to 64 bits; zero padding leaves the parity unchanged.
  function automatic logic parity_bit(input logic [63:0] data, input parity_mode_t mode);
    return (mode == PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Upstream socket read port: the socket offers words, the transmitter pulls them.
interface uart_tx_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  empty;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data;
  logic                  dv;

  modport master (output empty, output data, output dv, input rd_en);
  modport slave  (input empty, input data, input dv, output rd_en);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: o_tick marks the last clock of every bit period.
// Holding i_restart keeps the count at zero so a frame starts aligned.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  output logic o_tick
);
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign o_tick = (cnt == LAST);

  // Free-running bit counter, wrapping after CLKS_PER_BIT cycles
  always_ff @(posedge i_clk) begin
    if (i_rst || i_restart) begin
      cnt <= '0;
    end else if (o_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/uart_tx.sv
// Socket-fed UART transmitter: pulls words from the upstream socket, buffers
// one word and serialises it as start / data (LSB first) / [parity] / stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned STOP_BITS    = 1,
  parameter string       PARITY       = "none"
) (
  input  logic       i_clk,
  input  logic       i_rst,
  uart_tx_if.slave   sock,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_overflow
);
  localparam parity_mode_t MODE = (PARITY == PARITY_ODD)  ? PAR_ODD  :
                                  (PARITY == PARITY_EVEN) ? PAR_EVEN : PAR_NONE;
  localparam bit HAS_PARITY = (MODE != PAR_NONE);
  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] hold_q;
  logic [DATA_WIDTH-1:0] shifter;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  hold_valid;
  logic                  req_pending;
  logic                  par_q;
  logic                  stop_cnt;
  logic                  tick;
  logic                  baud_restart;
  logic                  stop_done;
  logic                  hold_free;

  assign baud_restart = (state == IDLE);
  assign o_busy       = (state != IDLE) || hold_valid || req_pending;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_restart(baud_restart),
    .o_tick   (tick)
  );

  // Hold is emptied whenever the FSM loads it into the shifter (idle or end of stop)
  always_comb begin
    stop_done = (state == STOP) && tick && (stop_cnt == STOP_LAST);
    hold_free = hold_valid && ((state == IDLE) || stop_done);
  end

  // Socket read request, one-word hold register and sticky overflow
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sock.rd_en  <= 1'b0;
      req_pending <= 1'b0;
      hold_valid  <= 1'b0;
      hold_q      <= '0;
      o_overflow  <= 1'b0;
    end else begin
      sock.rd_en <= 1'b0;
      if (sock.dv) begin
        req_pending <= 1'b0;
      end else if (!hold_valid && !req_pending && !sock.empty) begin
        sock.rd_en  <= 1'b1;
        req_pending <= 1'b1;
      end

      // A word landing on the cycle hold drains is accepted, not dropped
      if (sock.dv) begin
        if (!hold_valid || hold_free) begin
          hold_q     <= sock.data;
          hold_valid <= 1'b1;
        end else begin
          o_overflow <= 1'b1;
        end
      end else if (hold_free) begin
        hold_valid <= 1'b0;
      end
    end
  end

  // Frame sequencer with registered line output.
  // The PARITY state is package-qualified: the PARITY parameter shadows the import.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      o_tx     <= 1'b1;
      shifter  <= '0;
      par_q    <= 1'b0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_tx <= 1'b1;
          if (hold_valid) begin
            shifter <= hold_q;
            par_q   <= parity_bit(64'(hold_q), MODE);
            state   <= START;
            o_tx    <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            o_tx    <= shifter[0];
            shifter <= shifter >> 1;
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == BIT_LAST) begin
              if (HAS_PARITY) begin
                state <= uart_pkg::PARITY;
                o_tx  <= par_q;
              end else begin
                state    <= STOP;
                o_tx     <= 1'b1;
                stop_cnt <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              o_tx    <= shifter[0];
              shifter <= shifter >> 1;
            end
          end
        end
        uart_pkg::PARITY: begin
          if (tick) begin
            state    <= STOP;
            o_tx     <= 1'b1;
            stop_cnt <= 1'b0;
          end
        end
        STOP: begin
          if (tick) begin
            if (stop_cnt == STOP_LAST) begin
              if (hold_valid) begin
                shifter <= hold_q;
                par_q   <= parity_bit(64'(hold_q), MODE);
                state   <= START;
                o_tx    <= 1'b0;
              end else begin
                state <= IDLE;
                o_tx  <= 1'b1;
              end
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          o_tx  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (no parity / even + 2 stop / odd) at 4 clocks per bit,
// a latency-configurable socket model and a frame-level reference built from the line rules.
module tb_uart_tx;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_if #(.DATA_WIDTH(8)) sock0 ();
  uart_tx_if #(.DATA_WIDTH(8)) sock1 ();
  uart_tx_if #(.DATA_WIDTH(8)) sock2 ();

  logic tx0, tx1, tx2, busy0, busy1, busy2, ovf0, ovf1, ovf2;

  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(N), .STOP_BITS(1), .PARITY("none")) dut0 (
    .i_clk(clk), .i_rst(rst), .sock(sock0), .o_tx(tx0), .o_busy(busy0), .o_overflow(ovf0));
  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(N), .STOP_BITS(2), .PARITY("even")) dut1 (
    .i_clk(clk), .i_rst(rst), .sock(sock1), .o_tx(tx1), .o_busy(busy1), .o_overflow(ovf1));
  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(N), .STOP_BITS(1), .PARITY("odd")) dut2 (
    .i_clk(clk), .i_rst(rst), .sock(sock2), .o_tx(tx2), .o_busy(busy2), .o_overflow(ovf2));

  int n_tests = 0;
  int n_fail  = 0;

  // Socket model for dut0: words queued in src_mem are served lat cycles after a request;
  // inj_mem words are pushed unrequested, one per cycle.
  logic [7:0] src_mem [64];
  logic [7:0] inj_mem [16];
  int src_wr = 0, src_rd = 0, inj_wr = 0, inj_rd = 0;
  int lat = 2;
  int cd = 0;
  int rd_cnt = 0;

  always begin
    @(posedge clk);
    #1;
    if (inj_rd != inj_wr) begin
      sock0.dv   = 1'b1;
      sock0.data = inj_mem[inj_rd % 16];
      inj_rd++;
    end else if (cd == 1 && src_rd != src_wr) begin
      sock0.dv   = 1'b1;
      sock0.data = src_mem[src_rd % 64];
      src_rd++;
    end else begin
      sock0.dv = 1'b0;
    end
    if (cd > 0) cd--;
    sock0.empty = (src_rd == src_wr);
    @(negedge clk);
    if (sock0.rd_en === 1'b1) begin
      rd_cnt++;
      cd = lat;
    end
  end

  // Per-cycle line recorder (one sample per cycle, mid-cycle)
  logic rec_tx0 [$];
  logic rec_tx1 [$];
  logic rec_tx2 [$];
  logic rec_dv0 [$];
  always @(negedge clk) begin
    rec_tx0.push_back(tx0);
    rec_tx1.push_back(tx1);
    rec_tx2.push_back(tx2);
    rec_dv0.push_back(sock0.dv);
  end

  // Expected line samples for a sequence of frames
  logic exp_q [$];

  function automatic void push_frame(input logic [7:0] d, input int par, input int stops);
    logic pb;
    repeat (N) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (N) exp_q.push_back(d[i]);
    if (par != 0) begin
      pb = ($countones(d) % 2 == 1) ? 1'b1 : 1'b0;   // even: make the total count even
      if (par == 2) pb = ~pb;
      repeat (N) exp_q.push_back(pb);
    end
    repeat (stops * N) exp_q.push_back(1'b1);
  endfunction

  function automatic int rec_size(input int which);
    return (which == 0) ? rec_tx0.size() : (which == 1) ? rec_tx1.size() : rec_tx2.size();
  endfunction

  function automatic logic rec_at(input int which, input int i);
    return (which == 0) ? rec_tx0[i] : (which == 1) ? rec_tx1[i] : rec_tx2[i];
  endfunction

  function automatic int find_start(input int which, input int from);
    for (int i = from; i < rec_size(which); i++) if (rec_at(which, i) === 1'b0) return i;
    return -1;
  endfunction

  function automatic int find_dv(input int from);
    for (int i = from; i < rec_dv0.size(); i++) if (rec_dv0[i] === 1'b1) return i;
    return -1;
  endfunction

  // Offset of the first sample differing from exp_q, or -1 when all match
  function automatic int first_diff(input int which, input int s);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (s + i >= rec_size(which)) return i;
      if (rec_at(which, s + i) !== exp_q[i]) return i;
    end
    return -1;
  endfunction

  function automatic int zeros_from(input int which, input int from);
    int z = 0;
    for (int i = from; i < rec_size(which); i++) if (rec_at(which, i) !== 1'b1) z++;
    return z;
  endfunction

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_tests++;
      if ({tx0, tx1, tx2} !== 3'b111) begin
        n_fail++; $display("FAIL reset_tx cycle %0d: got %b expected 111", c, {tx0, tx1, tx2});
      end
      n_tests++;
      if (sock0.rd_en !== 1'b0) begin
        n_fail++; $display("FAIL reset_rd_en cycle %0d: got %b expected 0", c, sock0.rd_en);
      end
      n_tests++;
      if ({busy0, busy1, busy2} !== 3'b000) begin
        n_fail++; $display("FAIL reset_busy cycle %0d: got %b expected 000", c, {busy0, busy1, busy2});
      end
      n_tests++;
      if ({ovf0, ovf1, ovf2} !== 3'b000) begin
        n_fail++; $display("FAIL reset_overflow cycle %0d: got %b expected 000", c, {ovf0, ovf1, ovf2});
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycles(3);
  endtask

  task automatic test_single();
    int base, rd0, s, dvi, df;
    lat  = 2;
    base = rec_tx0.size();
    rd0  = rd_cnt;
    src_mem[src_wr % 64] = 8'hA5;
    src_wr++;
    cycles(60);
    dvi = find_dv(base);
    s   = find_start(0, base);
    n_tests++;
    if (s < 0 || dvi < 0 || s != dvi + 2) begin
      n_fail++; $display("FAIL single_latency: start-dv got %0d expected 2", s - dvi);
    end
    exp_q.delete();
    push_frame(8'hA5, 0, 1);
    df = (s < 0) ? 0 : first_diff(0, s);
    n_tests++;
    if (s < 0 || df != -1) begin
      n_fail++; $display("FAIL single_frame: sample %0d got %b expected %b", df,
                         (s < 0) ? 1'bx : rec_at(0, s + df), exp_q[df]);
    end
    n_tests++;
    if (s < 0 || zeros_from(0, s + 40) != 0) begin
      n_fail++; $display("FAIL single_idle_after: got %0d low samples expected 0",
                         (s < 0) ? -1 : zeros_from(0, s + 40));
    end
    n_tests++;
    if (rd_cnt - rd0 != 1) begin
      n_fail++; $display("FAIL single_rd_en: got %0d request cycles expected 1", rd_cnt - rd0);
    end
    n_tests++;
    if (busy0 !== 1'b0) begin
      n_fail++; $display("FAIL single_busy_end: got %b expected 0", busy0);
    end
  endtask

  task automatic test_parity();
    logic [7:0] vals [2];
    int base, df1, df2;
    logic pe;
    vals[0] = 8'h07;
    vals[1] = 8'($urandom);
    for (int k = 0; k < 2; k++) begin
      base = rec_tx1.size();
      sock1.data = vals[k]; sock1.dv = 1'b1;
      sock2.data = vals[k]; sock2.dv = 1'b1;
      cycles(1);
      sock1.dv = 1'b0;
      sock2.dv = 1'b0;
      cycles(60);
      pe = ($countones(vals[k]) % 2 == 1) ? 1'b1 : 1'b0;
      n_tests++;
      if (rec_at(1, base + 2 + 9 * N + 1) !== pe) begin
        n_fail++; $display("FAIL parity_even_bit data %h: got %b expected %b",
                           vals[k], rec_at(1, base + 2 + 9 * N + 1), pe);
      end
      n_tests++;
      if (rec_at(2, base + 2 + 9 * N + 1) !== ~pe) begin
        n_fail++; $display("FAIL parity_odd_bit data %h: got %b expected %b",
                           vals[k], rec_at(2, base + 2 + 9 * N + 1), ~pe);
      end
      exp_q.delete();
      push_frame(vals[k], 1, 2);
      df1 = first_diff(1, base + 2);
      n_tests++;
      if (df1 != -1 || zeros_from(1, base + 2 + 12 * N) != 0) begin
        n_fail++; $display("FAIL parity_even_stop2_frame data %h: sample %0d got %b expected %b",
                           vals[k], df1, rec_at(1, base + 2 + ((df1 < 0) ? 12 * N : df1)),
                           (df1 < 0) ? 1'b1 : exp_q[df1]);
      end
      exp_q.delete();
      push_frame(vals[k], 2, 1);
      df2 = first_diff(2, base + 2);
      n_tests++;
      if (df2 != -1 || zeros_from(2, base + 2 + 11 * N) != 0) begin
        n_fail++; $display("FAIL parity_odd_frame data %h: sample %0d got %b expected %b",
                           vals[k], df2, rec_at(2, base + 2 + ((df2 < 0) ? 11 * N : df2)),
                           (df2 < 0) ? 1'b1 : exp_q[df2]);
      end
      n_tests++;
      if ({busy1, busy2, sock1.rd_en, sock2.rd_en} !== 4'b0000) begin
        n_fail++; $display("FAIL parity_quiet_end: busy/rd_en got %b expected 0000",
                           {busy1, busy2, sock1.rd_en, sock2.rd_en});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [$];
    int base, rd0, s, df;
    for (int r = 0; r < 2; r++) begin
      words.delete();
      if (r == 0) begin
        words.push_back(8'h00); words.push_back(8'hFF); words.push_back(8'h55);
        lat = 2;
      end else begin
        repeat ($urandom_range(2, 5)) words.push_back(8'($urandom));
        lat = $urandom_range(1, 3);
      end
      base = rec_tx0.size();
      rd0  = rd_cnt;
      exp_q.delete();
      foreach (words[i]) begin
        src_mem[src_wr % 64] = words[i];
        src_wr++;
        push_frame(words[i], 0, 1);
      end
      cycles(words.size() * 40 + 30);
      s  = find_start(0, base);
      df = (s < 0) ? 0 : first_diff(0, s);
      n_tests++;
      if (s < 0 || df != -1) begin
        n_fail++; $display("FAIL b2b_frames round %0d (%0d words): sample %0d got %b expected %b",
                           r, words.size(), df, (s < 0) ? 1'bx : rec_at(0, s + df), exp_q[df]);
      end
      n_tests++;
      if (s < 0 || zeros_from(0, s + exp_q.size()) != 0) begin
        n_fail++; $display("FAIL b2b_idle_after round %0d: got %0d low samples expected 0", r,
                           (s < 0) ? -1 : zeros_from(0, s + exp_q.size()));
      end
      n_tests++;
      if (rd_cnt - rd0 != words.size()) begin
        n_fail++; $display("FAIL b2b_rd_en round %0d: got %0d expected %0d", r, rd_cnt - rd0, words.size());
      end
      n_tests++;
      if (ovf0 !== 1'b0 || busy0 !== 1'b0) begin
        n_fail++; $display("FAIL b2b_flags round %0d: overflow/busy got %b%b expected 00", r, ovf0, busy0);
      end
    end
  endtask

  task automatic test_overflow();
    int base, rd0, s, dvi, df;
    n_tests++;
    if (ovf0 !== 1'b0) begin
      n_fail++; $display("FAIL ovf_before: got %b expected 0", ovf0);
    end
    base = rec_tx0.size();
    rd0  = rd_cnt;
    inj_mem[inj_wr % 16] = 8'h11; inj_wr++;
    inj_mem[inj_wr % 16] = 8'h22; inj_wr++;
    inj_mem[inj_wr % 16] = 8'h33; inj_wr++;
    cycles(2 * 40 + 30);
    dvi = find_dv(base);
    s   = find_start(0, base);
    n_tests++;
    if (s < 0 || dvi < 0 || s != dvi + 2) begin
      n_fail++; $display("FAIL ovf_latency: start-dv got %0d expected 2", s - dvi);
    end
    exp_q.delete();
    push_frame(8'h11, 0, 1);
    push_frame(8'h22, 0, 1);
    df = (s < 0) ? 0 : first_diff(0, s);
    n_tests++;
    if (s < 0 || df != -1 || zeros_from(0, s + 80) != 0) begin
      n_fail++; $display("FAIL ovf_frames: sample %0d got %b expected %b", df,
                         (s < 0 || df < 0) ? 1'bx : rec_at(0, s + df), (df < 0) ? 1'b1 : exp_q[df]);
    end
    n_tests++;
    if (ovf0 !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set: got %b expected 1", ovf0);
    end
    n_tests++;
    if (rd_cnt != rd0) begin
      n_fail++; $display("FAIL ovf_no_request: got %0d requests expected 0", rd_cnt - rd0);
    end
    cycles(20);
    n_tests++;
    if (ovf0 !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sticky: got %b expected 1", ovf0);
    end
  endtask

  task automatic test_abort();
    logic [7:0] d, d2;
    int found, base, s, dvi, df;
    d = 8'($urandom) & 8'hF7;
    inj_mem[inj_wr % 16] = d; inj_wr++;
    found = 0;
    for (int k = 0; k < 30 && found == 0; k++) begin
      @(negedge clk);
      if (tx0 === 1'b0) found = 1;
    end
    n_tests++;
    if (found == 0) begin
      n_fail++; $display("FAIL abort_start: got no start bit expected one within 30 cycles");
    end else begin
      repeat (17) @(negedge clk);
      n_tests++;
      if (tx0 !== d[3]) begin
        n_fail++; $display("FAIL abort_bit3: got %b expected %b", tx0, d[3]);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_tests++;
      if ({tx0, busy0, ovf0, sock0.rd_en} !== 4'b1000) begin
        n_fail++; $display("FAIL abort_reset: tx/busy/ovf/rd_en got %b expected 1000",
                           {tx0, busy0, ovf0, sock0.rd_en});
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycles(3);
    d2   = 8'($urandom);
    base = rec_tx0.size();
    inj_mem[inj_wr % 16] = d2; inj_wr++;
    cycles(60);
    dvi = find_dv(base);
    s   = find_start(0, base);
    exp_q.delete();
    push_frame(d2, 0, 1);
    df = (s < 0) ? 0 : first_diff(0, s);
    n_tests++;
    if (s < 0 || s != dvi + 2 || df != -1 || zeros_from(0, s + 40) != 0) begin
      n_fail++; $display("FAIL abort_recovery data %h: start-dv %0d (expected 2), sample %0d got %b expected %b",
                         d2, s - dvi, df, (s < 0 || df < 0) ? 1'bx : rec_at(0, s + df),
                         (df < 0) ? 1'b1 : exp_q[df]);
    end
  endtask

  initial begin
    sock1.empty = 1'b1; sock1.dv = 1'b0; sock1.data = '0;
    sock2.empty = 1'b1; sock2.dv = 1'b0; sock2.data = '0;
    test_reset();
    test_single();
    test_parity();
    test_back_to_back();
    test_overflow();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
